// File: rtl/word_desconcatenador_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_split_pkg
//  Description : Shared types and elaboration helpers for the word splitter
//                (inverse of the RTC {segundo, primero} concatenation stage).
//  Revision    : 1.0 - initial release
// ============================================================================
package rtc_split_pkg;

  // Two-state controller: waiting for a word, or emitting its pieces.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Number of pieces a word is split into.
  function automatic int calc_n_pieces(input int word_w, input int piece_w);
    return word_w / piece_w;
  endfunction

  // Width of the piece index counter; never below one bit.
  function automatic int calc_cnt_w(input int n_pieces);
    return (n_pieces < 2) ? 1 : $clog2(n_pieces);
  endfunction

  // Legal geometry: whole number of pieces, and at least two of them.
  function automatic bit params_ok(input int word_w, input int piece_w);
    return (piece_w > 0) && ((word_w % piece_w) == 0) && ((word_w / piece_w) >= 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/word_desconcatenador_if.sv
`default_nettype none
// ============================================================================
//  Module      : word_desconcatenador_if
//  Description : Valid/ready bundle for the word splitter. The upstream side
//                offers words, the downstream side consumes pieces.
//  Revision    : 1.0 - initial release
// ============================================================================
interface word_desconcatenador_if #(
  parameter int WORD_W  = 8,
  parameter int PIECE_W = 2
);
  logic [WORD_W-1:0]  in_data;
  logic               in_valid;
  logic               in_ready;
  logic [PIECE_W-1:0] out_piece;
  logic               out_valid;
  logic               out_ready;
  logic               out_first;
  logic               out_last;
  logic               busy;

  // Environment view: drives words and piece acceptance.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_piece, out_valid, out_first, out_last, busy
  );

  // Splitter view.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_piece, out_valid, out_first, out_last, busy
  );
endinterface
`default_nettype wire

// File: rtl/word_desconcatenador_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : desconcat_shift_reg
//  Description : Load/shift register holding the word being split. Shifts
//                right by one piece with zero fill; load wins over shift.
//  Revision    : 1.0 - initial release
// ============================================================================
module desconcat_shift_reg #(
  parameter int WORD_W  = 8,
  parameter int PIECE_W = 2
) (
  input  wire logic               clk,
  input  wire logic               reset,
  input  wire logic               load,
  input  wire logic               shift,
  input  wire logic [WORD_W-1:0]  d,
  output      logic [PIECE_W-1:0] q
);

  logic [WORD_W-1:0] r_shreg;

  // Word storage: capture a new word, or drop the piece just consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg <= '0;
    end else if (load) begin
      r_shreg <= d;
    end else if (shift) begin
      r_shreg <= r_shreg >> PIECE_W;
    end
  end

  // The current piece always sits in the LSBs.
  assign q = r_shreg[PIECE_W-1:0];

endmodule
`default_nettype wire

// File: rtl/word_desconcatenador.sv
`default_nettype none
// ============================================================================
//  Module      : word_desconcatenador
//  Description : Splits a WORD_W word into WORD_W/PIECE_W pieces, emitted
//                LSB piece first, one per output handshake. A new word can be
//                taken on the same cycle the last piece leaves (no bubble).
//  Revision    : 1.0 - initial release
// ============================================================================
module word_desconcatenador
  import rtc_split_pkg::*;
#(
  parameter int WORD_W  = 8,
  parameter int PIECE_W = 2
) (
  input wire logic              clk,
  input wire logic              reset,
  word_desconcatenador_if.slave bus
);

  localparam int N_PIECES = calc_n_pieces(WORD_W, PIECE_W);
  localparam int c_CNT_W  = calc_cnt_w(N_PIECES);
  localparam logic [c_CNT_W-1:0] c_LAST_IDX = c_CNT_W'(N_PIECES - 1);
  localparam logic [c_CNT_W-1:0] c_IDX_ONE  = c_CNT_W'(1);

  // Reject geometries that cannot be split into two or more whole pieces.
  generate
    if (!params_ok(WORD_W, PIECE_W)) begin : g_param_check
      $error("word_desconcatenador: WORD_W must be a multiple of PIECE_W with at least 2 pieces");
    end
  endgenerate

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_idx;
  logic [c_CNT_W-1:0] w_idx_nxt;
  logic               w_load;
  logic               w_shift;
  logic               w_last;
  logic [PIECE_W-1:0] w_piece;

  assign w_last = (r_idx == c_LAST_IDX);

  // Controller state and piece index.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next state, index and shift-register control from both handshakes.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_state_nxt = EMIT;
          w_idx_nxt   = '0;
          w_load      = 1'b1;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (!w_last) begin
            w_idx_nxt = r_idx + c_IDX_ONE;
            w_shift   = 1'b1;
          end else if (bus.in_valid) begin
            // Last piece leaves while the next word arrives: reload in place.
            w_idx_nxt = '0;
            w_load    = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  desconcat_shift_reg #(
    .WORD_W  (WORD_W),
    .PIECE_W (PIECE_W)
  ) u_shreg (
    .clk   (clk),
    .reset (reset),
    .load  (w_load),
    .shift (w_shift),
    .d     (bus.in_data),
    .q     (w_piece)
  );

  // out_ready -> in_ready is the single combinational path through the block.
  assign bus.in_ready  = (r_state == IDLE) || (w_last && bus.out_ready);
  assign bus.out_piece = w_piece;
  assign bus.out_valid = (r_state == EMIT);
  assign bus.busy      = (r_state == EMIT);
  assign bus.out_first = (r_idx == '0);
  assign bus.out_last  = w_last;

endmodule
`default_nettype wire

// File: tb/tb_word_desconcatenador.sv
`default_nettype none
// ============================================================================
//  Module      : tb_word_desconcatenador
//  Description : Self-checking bench for the word splitter, 8/2 and 16/4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_word_desconcatenador;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  word_desconcatenador_if #(.WORD_W(8),  .PIECE_W(2)) bus_a ();
  word_desconcatenador_if #(.WORD_W(16), .PIECE_W(4)) bus_b ();

  word_desconcatenador #(.WORD_W(8), .PIECE_W(2)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  word_desconcatenador #(.WORD_W(16), .PIECE_W(4)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model for the 8/2 instance: a queue of pending pieces.
  typedef struct {
    logic [1:0] val;
    bit         first;
    bit         last;
  } piece_t;

  piece_t m_q[$];
  bit     m_zero;   // piece register known to be zero (just reset)

  function automatic bit m_in_ready(input bit ordy);
    return (m_q.size() == 0) || ((m_q.size() == 1) && ordy);
  endfunction

  // One clock of the 8/2 instance: inputs are already driven.
  task automatic cycle(input int exp_piece = -1);
    bit acc;
    @(negedge clk);
    check_val("in_ready", bus_a.in_ready, m_in_ready(bus_a.out_ready));
    check_val("out_valid", bus_a.out_valid, (m_q.size() > 0));
    check_val("busy", bus_a.busy, (m_q.size() > 0));
    if (m_q.size() > 0) begin
      check_val("out_piece", bus_a.out_piece, m_q[0].val);
      check_val("out_first", bus_a.out_first, m_q[0].first);
      check_val("out_last", bus_a.out_last, m_q[0].last);
    end else begin
      check_val("idle_first", bus_a.out_first, 1);
      check_val("idle_last", bus_a.out_last, 0);
      if (m_zero) check_val("idle_piece", bus_a.out_piece, 0);
    end
    if (exp_piece >= 0) check_val("piece_const", bus_a.out_piece, exp_piece);
    @(posedge clk);
    if (reset) begin
      m_q.delete();
      m_zero = 1'b1;
    end else begin
      acc = bus_a.in_valid && m_in_ready(bus_a.out_ready);
      if ((m_q.size() > 0) && bus_a.out_ready) void'(m_q.pop_front());
      if (acc) begin
        for (int i = 0; i < 4; i++) begin
          piece_t p;
          p.val   = 2'((bus_a.in_data >> (2 * i)) & 8'h03);
          p.first = (i == 0);
          p.last  = (i == 3);
          m_q.push_back(p);
        end
        m_zero = 1'b0;
      end
    end
    #1;
  endtask

  logic [3:0] sweep_exp [4];

  initial begin
    reset           = 1'b1;
    bus_a.in_valid  = 1'b0;
    bus_a.in_data   = '0;
    bus_a.out_ready = 1'b0;
    bus_b.in_valid  = 1'b0;
    bus_b.in_data   = '0;
    bus_b.out_ready = 1'b0;

    // Reset then idle.
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_in_ready", bus_a.in_ready, 1);
    check_val("rst_out_valid", bus_a.out_valid, 0);
    check_val("rst_busy", bus_a.busy, 0);
    check_val("rst_piece", bus_a.out_piece, 0);
    check_val("rst_first", bus_a.out_first, 1);
    check_val("rst_last", bus_a.out_last, 0);
    m_q.delete();
    m_zero = 1'b1;
    cycle();
    reset = 1'b0;
    repeat (2) cycle();

    // Single word.
    bus_a.out_ready = 1'b1;
    bus_a.in_valid  = 1'b1;
    bus_a.in_data   = 8'hB4;
    cycle();
    bus_a.in_valid = 1'b0;
    cycle(0); cycle(1); cycle(3); cycle(2);
    repeat (2) cycle();

    // Back-to-back words.
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 8'hB4;
    cycle();
    bus_a.in_data = 8'h1E;
    cycle(0); cycle(1); cycle(3); cycle(2);
    bus_a.in_valid = 1'b0;
    cycle(2); cycle(3); cycle(1); cycle(0);
    cycle();

    // Stall on piece 1, with in_data wiggling while busy.
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 8'hB4;
    cycle();
    bus_a.in_valid = 1'b0;
    cycle(0);
    bus_a.out_ready = 1'b0;
    repeat (3) begin
      bus_a.in_data = 8'($urandom);
      cycle(1);
    end
    bus_a.out_ready = 1'b1;
    cycle(1); cycle(3); cycle(2);
    cycle();

    // Reset in the middle of a word.
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 8'hFF;
    cycle();
    bus_a.in_valid = 1'b0;
    cycle(3); cycle(3);
    reset = 1'b1;
    cycle(3);
    reset = 1'b0;
    repeat (2) cycle();
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 8'h00;
    cycle();
    bus_a.in_valid = 1'b0;
    cycle(0); cycle(0); cycle(0); cycle(0);
    cycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      bus_a.in_valid  = 1'($urandom_range(0, 1));
      bus_a.in_data   = 8'($urandom);
      bus_a.out_ready = ($urandom_range(0, 3) != 0);
      reset           = ($urandom_range(0, 63) == 0);
      cycle();
    end
    reset           = 1'b0;
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
    repeat (5) cycle();

    // Parameter sweep: 16-bit word, 4-bit pieces.
    sweep_exp[0] = 4'h4;
    sweep_exp[1] = 4'h3;
    sweep_exp[2] = 4'h2;
    sweep_exp[3] = 4'h1;
    bus_b.out_ready = 1'b1;
    bus_b.in_valid  = 1'b1;
    bus_b.in_data   = 16'h1234;
    @(negedge clk);
    check_val("b_in_ready", bus_b.in_ready, 1);
    @(posedge clk);
    #1;
    bus_b.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("b_valid", bus_b.out_valid, 1);
      check_val("b_piece", bus_b.out_piece, sweep_exp[i]);
      check_val("b_first", bus_b.out_first, (i == 0));
      check_val("b_last", bus_b.out_last, (i == 3));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check_val("b_idle_valid", bus_b.out_valid, 0);
    check_val("b_idle_busy", bus_b.busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
